// File: rtl/decode_pipe_pkg.sv
// rtl/decode_pipe_pkg.sv - opcodes, control-bus layout and decode table for decode_pipe
package decode_pipe_pkg;

    localparam int EX_W  = 4;
    localparam int MEM_W = 3;
    localparam int WB_W  = 2;

    // memory_bus bit positions
    localparam int MEM_READ_BIT  = 2;
    localparam int MEM_WRITE_BIT = 1;
    localparam int BRANCH_BIT    = 0;

    // writeBack_bus bit positions
    localparam int WB_REGWRITE_BIT = 1;
    localparam int WB_MEMTOREG_BIT = 0;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_BEQ   = 6'b000100,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    // execute bus: [3]=RegDst, [2:1]=ALUOp, [0]=ALUSrc
    typedef struct packed {
        logic [EX_W-1:0]  ex;
        logic [MEM_W-1:0] mem;
        logic [WB_W-1:0]  wb;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    function automatic ctrl_t decode_opcode(input logic [5:0] op);
        ctrl_t c;
        c = CTRL_NONE;
        case (op)
            OP_RTYPE: begin
                c.ex  = 4'b1100;
                c.wb  = 2'b10;
            end
            OP_LW: begin
                c.ex  = 4'b0001;
                c.mem = 3'b100;
                c.wb  = 2'b11;
            end
            OP_SW: begin
                c.ex  = 4'b0001;
                c.mem = 3'b010;
            end
            OP_BEQ: begin
                c.ex  = 4'b0010;
                c.mem = 3'b001;
            end
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - 2**NB x len register file, two async read ports, write-through bypass
// Ports: clk/reset (sync, active-high), we/wa/wd write port, ra1/ra2 read indices, rd1/rd2 read data.
module regfile_bypass #(
    parameter int len = 32,
    parameter int NB  = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [NB-1:0] wa,
    input  logic [len-1:0] wd,
    input  logic [NB-1:0] ra1,
    input  logic [NB-1:0] ra2,
    output logic [len-1:0] rd1,
    output logic [len-1:0] rd2
);

    logic [len-1:0] regs [2**NB];

    // Reset wins over a same-cycle write; r0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2**NB; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // A same-cycle write to the index being read is forwarded so decode
    // sees the value writeback is committing this edge.
    always_comb begin
        rd1 = '0;
        if (ra1 != '0) begin
            rd1 = (we && (wa == ra1)) ? wd : regs[ra1];
        end
    end

    always_comb begin
        rd2 = '0;
        if (ra2 != '0) begin
            rd2 = (we && (wa == ra2)) ? wd : regs[ra2];
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - instruction decode stage with ID/EX register and load-use stall
// Ports: clk/reset (sync, active-high); in_* IF/ID entry and flush; RegWrite/write_register/
// write_data writeback port; out_stall combinational hazard; out_* and *_bus registered ID/EX entry.
module decode_pipe
    import decode_pipe_pkg::*;
#(
    parameter int len = 32,
    parameter int NB  = $clog2(len)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [len-1:0]    in_pc_jump,
    input  logic [len-1:0]    in_instruccion,
    input  logic              in_flush,
    input  logic              RegWrite,
    input  logic [NB-1:0]     write_register,
    input  logic [len-1:0]    write_data,
    output logic              out_stall,
    output logic              out_valid,
    output logic [len-1:0]    out_pc_jump,
    output logic [len-1:0]    out_reg1,
    output logic [len-1:0]    out_reg2,
    output logic [len-1:0]    out_sign_extend,
    output logic [NB-1:0]     out_rs,
    output logic [NB-1:0]     out_rt,
    output logic [NB-1:0]     out_rd,
    output logic [NB-1:0]     out_shamt,
    output logic [EX_W-1:0]   execute_bus,
    output logic [MEM_W-1:0]  memory_bus,
    output logic [WB_W-1:0]   writeBack_bus
);

    logic [5:0]     opcode;
    logic [NB-1:0]  rs, rt, rd, shamt;
    logic [15:0]    imm;
    logic [len-1:0] rd1, rd2, sext;
    ctrl_t          ctrl;
    logic           bubble;

    assign opcode = in_instruccion[31:26];
    assign rs     = NB'(in_instruccion[25:21]);
    assign rt     = NB'(in_instruccion[20:16]);
    assign rd     = NB'(in_instruccion[15:11]);
    assign shamt  = NB'(in_instruccion[10:6]);
    assign imm    = in_instruccion[15:0];
    assign sext   = {{(len-16){imm[15]}}, imm};
    assign ctrl   = decode_opcode(opcode);

    regfile_bypass #(.len(len), .NB(NB)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (RegWrite),
        .wa    (write_register),
        .wd    (write_data),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rd1),
        .rd2   (rd2)
    );

    // Load in EX whose destination is a source here. A flushed or empty
    // IF/ID entry never stalls, since it becomes a bubble anyway.
    assign out_stall = out_valid && memory_bus[MEM_READ_BIT] && (out_rt != '0)
                     && in_valid && !in_flush
                     && ((out_rt == rs) || (out_rt == rt));

    assign bubble = in_flush || !in_valid || out_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid       <= 1'b0;
            execute_bus     <= '0;
            memory_bus      <= '0;
            writeBack_bus   <= '0;
            out_pc_jump     <= '0;
            out_reg1        <= '0;
            out_reg2        <= '0;
            out_sign_extend <= '0;
            out_rs          <= '0;
            out_rt          <= '0;
            out_rd          <= '0;
            out_shamt       <= '0;
        end else begin
            // Data fields are captured even for bubbles; only valid and
            // control decide whether the entry does anything downstream.
            out_pc_jump     <= in_pc_jump;
            out_reg1        <= rd1;
            out_reg2        <= rd2;
            out_sign_extend <= sext;
            out_rs          <= rs;
            out_rt          <= rt;
            out_rd          <= rd;
            out_shamt       <= shamt;
            if (bubble) begin
                out_valid     <= 1'b0;
                execute_bus   <= '0;
                memory_bus    <= '0;
                writeBack_bus <= '0;
            end else begin
                out_valid     <= 1'b1;
                execute_bus   <= ctrl.ex;
                memory_bus    <= ctrl.mem;
                writeBack_bus <= ctrl.wb;
            end
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - scoreboard bench for decode_pipe
module tb_decode_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc_jump;
    logic [31:0] in_instruccion;
    logic        in_flush;
    logic        RegWrite;
    logic [4:0]  write_register;
    logic [31:0] write_data;
    logic        out_stall;
    logic        out_valid;
    logic [31:0] out_pc_jump, out_reg1, out_reg2, out_sign_extend;
    logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
    logic [3:0]  execute_bus;
    logic [2:0]  memory_bus;
    logic [1:0]  writeBack_bus;

    always #5 clk = ~clk;

    decode_pipe #(.len(32), .NB(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_pc_jump      (in_pc_jump),
        .in_instruccion  (in_instruccion),
        .in_flush        (in_flush),
        .RegWrite        (RegWrite),
        .write_register  (write_register),
        .write_data      (write_data),
        .out_stall       (out_stall),
        .out_valid       (out_valid),
        .out_pc_jump     (out_pc_jump),
        .out_reg1        (out_reg1),
        .out_reg2        (out_reg2),
        .out_sign_extend (out_sign_extend),
        .out_rs          (out_rs),
        .out_rt          (out_rt),
        .out_rd          (out_rd),
        .out_shamt       (out_shamt),
        .execute_bus     (execute_bus),
        .memory_bus      (memory_bus),
        .writeBack_bus   (writeBack_bus)
    );

    typedef struct {
        logic        valid;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic        ex_zero;
        logic        chk;
        logic [31:0] pc, r1, r2, sx;
        logic [4:0]  rs, rt, rd, sh;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mrf [32];
    logic        m_valid = 1'b0;
    logic        m_memrd = 1'b0;
    logic [4:0]  m_rt    = 5'd0;
    logic [31:0] pc_n    = 32'd0;
    int          compared   = 0;
    int          mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic step(input string tag, input logic rst, input logic v, input logic fl,
                        input logic [31:0] ins, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd);
        exp_t        e, g;
        logic        es;
        logic [4:0]  rs_i, rt_i;
        logic [2:0]  mem;
        logic [1:0]  wb;
        logic        known;
        reset = rst; in_valid = v; in_flush = fl; in_instruccion = ins;
        RegWrite = we; write_register = wa; write_data = wd;
        pc_n = pc_n + 32'd4; in_pc_jump = pc_n;
        #1;
        rs_i = ins[25:21];
        rt_i = ins[20:16];
        es = m_valid && m_memrd && (m_rt != 5'd0) && v && !fl && ((m_rt == rs_i) || (m_rt == rt_i));
        chk({tag, ".stall"}, {31'd0, out_stall}, {31'd0, es});

        known = 1'b1; mem = 3'b000; wb = 2'b00;
        case (ins[31:26])
            6'b000000: wb = 2'b10;
            6'b100011: begin mem = 3'b100; wb = 2'b11; end
            6'b101011: mem = 3'b010;
            6'b000100: mem = 3'b001;
            default:   known = 1'b0;
        endcase

        e.pc = pc_n;
        e.r1 = (rs_i == 5'd0) ? 32'd0 : ((we && wa == rs_i) ? wd : mrf[rs_i]);
        e.r2 = (rt_i == 5'd0) ? 32'd0 : ((we && wa == rt_i) ? wd : mrf[rt_i]);
        e.sx = {{16{ins[15]}}, ins[15:0]};
        e.rs = rs_i; e.rt = rt_i; e.rd = ins[15:11]; e.sh = ins[10:6];
        if (rst) begin
            e.valid = 1'b0; e.mem = 3'b000; e.wb = 2'b00; e.ex_zero = 1'b1; e.chk = 1'b1;
            e.pc = '0; e.r1 = '0; e.r2 = '0; e.sx = '0;
            e.rs = '0; e.rt = '0; e.rd = '0; e.sh = '0;
        end else if (fl || !v || es) begin
            e.valid = 1'b0; e.mem = 3'b000; e.wb = 2'b00; e.ex_zero = 1'b1; e.chk = 1'b0;
        end else begin
            e.valid = 1'b1; e.mem = mem; e.wb = wb; e.ex_zero = !known; e.chk = 1'b1;
        end
        sb.push_back(e);

        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        end else if (we && wa != 5'd0) begin
            mrf[wa] = wd;
        end
        #1;

        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL %s.queue: observed empty expected entry", tag);
        end else begin
            g = sb.pop_front();
            chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, g.valid});
            chk({tag, ".mem"},   {29'd0, memory_bus}, {29'd0, g.mem});
            chk({tag, ".wb"},    {30'd0, writeBack_bus}, {30'd0, g.wb});
            if (g.ex_zero) chk({tag, ".ex"}, {28'd0, execute_bus}, 32'd0);
            if (g.chk) begin
                chk({tag, ".pc"},   out_pc_jump, g.pc);
                chk({tag, ".reg1"}, out_reg1, g.r1);
                chk({tag, ".reg2"}, out_reg2, g.r2);
                chk({tag, ".sext"}, out_sign_extend, g.sx);
                chk({tag, ".rs"},   {27'd0, out_rs}, {27'd0, g.rs});
                chk({tag, ".rt"},   {27'd0, out_rt}, {27'd0, g.rt});
                chk({tag, ".rd"},   {27'd0, out_rd}, {27'd0, g.rd});
                chk({tag, ".shamt"}, {27'd0, out_shamt}, {27'd0, g.sh});
            end
            m_valid = g.valid;
            m_memrd = g.mem[2];
            m_rt    = g.rt;
        end
    endtask

    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_flush = 1'b0; in_instruccion = '0;
        in_pc_jump = '0; RegWrite = 1'b0; write_register = '0; write_data = '0;
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        @(posedge clk); #1;

        // reset state, with a write in the reset cycle that must be dropped
        step("rst",     1, 0, 0, 32'h0, 1, 5'd5, 32'hDEAD_BEEF);
        step("rdzero",  0, 1, 0, r_type(5'd5, 5'd6, 5'd1), 0, 5'd0, 32'h0);

        // write r5 then ADD r3,r5,r0
        step("wr5",     0, 0, 0, 32'h0, 1, 5'd5, 32'h0000_00AA);
        step("add",     0, 1, 0, r_type(5'd5, 5'd0, 5'd3), 0, 5'd0, 32'h0);

        // bypass: write r7 while reading rs=7
        step("bypass",  0, 1, 0, r_type(5'd7, 5'd5, 5'd1), 1, 5'd7, 32'h0000_1234);
        step("wr0",     0, 0, 0, 32'h0, 1, 5'd0, 32'hFFFF_FFFF);
        step("rd0",     0, 1, 0, r_type(5'd0, 5'd0, 5'd2), 0, 5'd0, 32'h0);
        step("rd0byp",  0, 1, 0, r_type(5'd0, 5'd7, 5'd2), 1, 5'd0, 32'h5555_5555);

        // load-use: LW r4,0(r1); ADD r2,r4,r4 stalls once then issues
        step("lw4",     0, 1, 0, i_type(LW, 5'd1, 5'd4, 16'h0000), 0, 5'd0, 32'h0);
        step("addstl",  0, 1, 0, r_type(5'd4, 5'd4, 5'd2), 0, 5'd0, 32'h0);
        step("addgo",   0, 1, 0, r_type(5'd4, 5'd4, 5'd2), 0, 5'd0, 32'h0);

        // LW r0 then use of r0: no stall
        step("lw0",     0, 1, 0, i_type(LW, 5'd1, 5'd0, 16'h0008), 0, 5'd0, 32'h0);
        step("use0",    0, 1, 0, r_type(5'd0, 5'd3, 5'd2), 0, 5'd0, 32'h0);

        // LW r4 then SW using rt=4 with negative offset
        step("lw4b",    0, 1, 0, i_type(LW, 5'd1, 5'd4, 16'h0010), 0, 5'd0, 32'h0);
        step("swstl",   0, 1, 0, i_type(SW, 5'd1, 5'd4, 16'hFFFC), 1, 5'd4, 32'h0000_0777);
        step("swgo",    0, 1, 0, i_type(SW, 5'd1, 5'd4, 16'hFFFC), 0, 5'd0, 32'h0);

        // flush with BEQ under a load-use hazard
        step("lw4c",    0, 1, 0, i_type(LW, 5'd1, 5'd4, 16'h0000), 0, 5'd0, 32'h0);
        step("flush",   0, 1, 1, i_type(BEQ, 5'd4, 5'd4, 16'h0003), 0, 5'd0, 32'h0);
        step("beq",     0, 1, 0, i_type(BEQ, 5'd4, 5'd5, 16'h8001), 0, 5'd0, 32'h0);

        // unknown opcode and an empty IF/ID slot
        step("unk",     0, 1, 0, i_type(6'b111111, 5'd5, 5'd7, 16'h1234), 0, 5'd0, 32'h0);
        step("empty",   0, 0, 0, r_type(5'd5, 5'd7, 5'd1), 0, 5'd0, 32'h0);

        // reset mid-stall with a write in the same cycle
        step("lw4d",    0, 1, 0, i_type(LW, 5'd1, 5'd4, 16'h0000), 0, 5'd0, 32'h0);
        step("rststl",  1, 1, 0, r_type(5'd4, 5'd9, 5'd2), 1, 5'd9, 32'hCAFE_F00D);
        step("postrst", 0, 1, 0, r_type(5'd4, 5'd9, 5'd2), 0, 5'd0, 32'h0);
        step("rdr5",    0, 1, 0, r_type(5'd5, 5'd7, 5'd1), 0, 5'd0, 32'h0);

        chk("sb.empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
DECODE_PIPE -- requirements
Module: decode_pipe

Interface
REQ-001 Parameter len, default 32, data/instruction/PC width.
REQ-002 Parameter NB, default $clog2(len), register-index width; register file depth 2**NB.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high.
REQ-005 in_valid  input  1  IF/ID entry holds a real instruction.
REQ-006 in_pc_jump  input  len  PC+4 of the incoming instruction.
REQ-007 in_instruccion  input  len  instruction word; opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], imm [15:0].
REQ-008 in_flush  input  1  branch/jump taken; squash the instruction in decode.
REQ-009 RegWrite  input  1  writeback enable.
REQ-010 write_register  input  NB  writeback destination index.
REQ-011 write_data  input  len  writeback data.
REQ-012 out_stall  output  1  combinational load-use hazard; IF and IF/ID hold when high.
REQ-013 out_valid  output  1  registered; ID/EX entry is a real instruction.
REQ-014 out_pc_jump, out_reg1, out_reg2, out_sign_extend  output  len each  registered ID/EX data.
REQ-015 out_rs, out_rt, out_rd, out_shamt  output  NB each  registered ID/EX fields.
REQ-016 execute_bus [3:0], memory_bus [2:0], writeBack_bus [1:0]  output  registered control; memory_bus[2]=MemRead, memory_bus[1]=MemWrite, memory_bus[0]=Branch, writeBack_bus[1]=RegWrite, writeBack_bus[0]=MemtoReg.

Function
REQ-017 All ID/EX outputs SHALL be registered, with 1-cycle latency from in_instruccion to outputs.
REQ-018 Opcode decode SHALL follow the package table: R-type 000000 -> wb 2'b10; LW 100011 -> mem 3'b100, wb 2'b11; SW 101011 -> mem 3'b010, wb 2'b00; BEQ 000100 -> mem 3'b001; unknown opcode -> all control buses zero.
REQ-019 The register file SHALL have 2**NB entries of len bits, with two combinational read ports (rs, rt) and one write port active on RegWrite at the clock edge.
REQ-020 Register 0 SHALL always read zero; writes to index 0 SHALL be ignored.
REQ-021 Write-through bypass: when RegWrite=1 and write_register equals a nonzero read index in the same cycle, that read port SHALL return write_data.
REQ-022 out_sign_extend SHALL equal imm[15:0] sign-extended to len bits.
REQ-023 out_stall SHALL be 1 iff out_valid and memory_bus[2] and out_rt!=0 and in_valid and (out_rt==rs or out_rt==rt).
REQ-024 When out_stall=1, the next ID/EX entry SHALL be a bubble (out_valid=0, all control buses zero); data fields are don't-care.
REQ-025 When in_flush=1 or in_valid=0, the next ID/EX entry SHALL be a bubble, and out_stall SHALL be forced to 0.
REQ-026 Priority SHALL be reset > in_flush > stall bubble > normal capture.
REQ-027 A stalled instruction SHALL pass in the cycle after the stall, because the bubble clears the hazard; the stall lasts exactly 1 cycle per load-use pair.
REQ-028 Register-file writes SHALL proceed regardless of stall or flush.

Reset
REQ-029 Reset SHALL set out_valid and all control buses to 0, and all ID/EX data and field outputs to 0.
REQ-030 Register-file contents SHALL be cleared to 0 on reset, and a write in the reset cycle SHALL be discarded.
REQ-031 Reset asserted mid-stall SHALL drop the stall on the next cycle, because out_valid=0.

Structure
REQ-032 A shared package SHALL hold the opcode constants, control-bus widths, bus bit positions and the decode table.
REQ-033 The register file SHALL be a single sub-module named regfile_bypass, parametrised by len and NB.
REQ-034 Hazard detection and the opcode decode SHALL live in decode_pipe.

Verification
REQ-035 Write r5=0x0000_00AA, then send ADD r3,r5,r0 -> one cycle later out_reg1=0xAA, writeBack_bus=2'b10, out_valid=1.
REQ-036 Write r7=0x1234 in the same cycle that an instruction reads rs=7 -> out_reg1=0x1234 (bypass); a write to r0=0xFFFF_FFFF followed by a read of r0 -> 0.
REQ-037 Send LW r4,0(r1) followed by ADD r2,r4,r4 -> out_stall=1 for 1 cycle and a bubble (out_valid=0) is inserted; then the ADD issues with out_rs=4.
REQ-038 Send LW r0 followed by a use of r0 -> no stall; LW r4 followed by SW using rt=4 -> stall.
REQ-039 Assert in_flush with a valid BEQ and a load-use hazard present -> next cycle out_valid=0, out_stall=0, control buses zero.
REQ-040 Assert reset during a stall and during a write -> all outputs zero next cycle, and register reads return 0.
